dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory port. It replaces the zero-wait dmem with a handshaked, fixed-latency memory.
- Accepts one load/store request at a time from the pipeline's M stage and returns read data or a store acknowledge LATENCY cycles later.
- The pipeline's hazard unit uses `stall_m` to freeze F/D/E/M while a request is outstanding.
- After reset it sweeps the array to zero before accepting any traffic.

Parameters:
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  M stage presents a memory request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address (`alu_out_M[ADDR_W+1:2]`)
- req_wdata  in  32  store data (`wd_dm_M`)
- req_ready  out  1  responder can accept a request this cycle
- rsp_valid  out  1  one-cycle pulse: response for the accepted request
- rsp_rdata  out  32  load data; 0 for store responses
- stall_m  out  1  `req_valid & ~req_ready`, or an accepted request not yet responded
- busy_clr  out  1  high while the post-reset clear sweep runs

Behaviour:
- Reset values: state=CLEAR, clr_cnt=0, lat_cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, busy_clr=1. `rst` overrides everything, including mid-transaction: the pending request is dropped, no response is issued, and the sweep restarts.
- CLEAR:
  - Writes 0 to `mem[clr_cnt]` and increments `clr_cnt` each cycle.
  - After writing DEPTH-1, goes to IDLE. The sweep takes exactly DEPTH cycles; `busy_clr` drops in the first IDLE cycle.
  - `req_ready` is 0 throughout.
- IDLE:
  - `req_ready` is 1.
  - If `req_valid` is high at an edge, the responder latches `we`, `addr` and `wdata`, loads `lat_cnt` = LATENCY-1, and goes to WAIT.
  - If LATENCY=1, it goes straight to RESP instead.
- WAIT:
  - `req_ready` is 0; `lat_cnt` decrements each cycle.
  - When `lat_cnt` is 0, goes to RESP.
  - Request inputs are ignored in this state.
- RESP (exactly one cycle):
  - `rsp_valid` is 1.
  - Load: `rsp_rdata = mem[addr_q]`.
  - Store: at the edge ending RESP, `mem[addr_q] <= wdata_q` and `rsp_rdata = 0`.
  - `req_ready` is 1 in RESP, so a new request can be accepted on the same edge (back-to-back).
  - Without a new request, next state is IDLE.
- Timing:
  - Accept at edge T gives `rsp_valid` high in cycle T+LATENCY.
  - Sustained throughput is one request per LATENCY cycles; LATENCY=1 gives one per cycle.
- Hazards:
  - A load to the same address accepted in the RESP cycle of a store sees the new data. This is a required bypass: store data is forwarded when `addr_q` matches.
  - `rsp_rdata` holds its last value outside RESP; only `rsp_valid` qualifies it.
- Address is truncated to ADDR_W bits; wrap-around is silent.

Optional Feature:
- Macro: DMEM_BYTE_EN_EN.
- With the macro:
  - Adds port `req_be` (in, 4): per-byte write enables.
  - A store writes only lanes whose bit is 1; `be=4'b0000` is a no-op store that still produces `rsp_valid`.
  - The bypass merges per lane.
  - Loads ignore `req_be`.
- Without the macro: no port; every store writes all 32 bits.

Decomposition:
- Package `dmem_pkg`:
  - `WORD_W=32`
  - `dmem_state_t` enum {CLEAR, IDLE, WAIT, RESP}
  - `LAT_W=4`
- Sub-module `dmem_array`:
  - Single-port DEPTH x 32 RAM.
  - Synchronous write with optional byte mask, asynchronous read.
  - Shared by the clear sweep and store commit via a write mux in `dmem_responder`.

Test Plan:
- Reset, ADDR_W=6 -> `busy_clr` and `req_ready`=0 for exactly 64 cycles; then load addr 0x3F returns `rsp_rdata`=0.
- LATENCY=2: store 0xDEADBEEF to addr 5 at edge T -> `rsp_valid` in cycle T+2. A following load of addr 5 -> `rsp_rdata`=0xDEADBEEF two cycles after its acceptance.
- Back-to-back: store 0x12345678 to addr 9, and a load of addr 9 accepted in the store's RESP cycle -> load returns 0x12345678 (bypass). `stall_m` asserts correctly throughout.
- LATENCY=1: four consecutive loads of addrs 1..4 -> four consecutive `rsp_valid` cycles, no stall cycles.
- `rst` asserted in WAIT of a store to addr 7 -> no `rsp_valid`, the clear sweep restarts, addr 7 reads 0 afterwards.
- DMEM_BYTE_EN_EN: store 0xAABBCCDD, then store 0x11223344 with `be`=4'b0101 -> load returns 0xAA22CC44.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   WORD_W       data word width
//   LAT_W        width of the response-latency down-counter
//   BE_W         number of byte lanes in a word
//   dmem_state_t responder FSM states
//   merge_bytes  lane-wise merge of a new word into an old one
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LAT_W  = 4;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dmem_state_t;

    // Lanes whose enable bit is set take the new byte; the rest keep the old one.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORD_W storage with one synchronous write port
// (byte-lane masked) and one asynchronous read port.
// Ports:
//   clk_i     clock, rising edge
//   we_i      write enable
//   be_i      per-byte write mask, applied only when we_i is high
//   waddr_i   write word address
//   wdata_i   write data
//   raddr_i   read word address
//   rdata_o   combinational read data
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked, fixed-latency responder for the core's data
// memory port. One request is outstanding at a time; the response (load data
// or store acknowledge) appears LATENCY cycles after acceptance. After reset
// the whole array is swept to zero before any request is accepted.
//
// Optional build macro: DMEM_BYTE_EN_EN adds req_be for per-byte stores.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  M stage presents a request
//   req_we     1 = store, 0 = load
//   req_addr   word address
//   req_wdata  store data
//   req_be     per-byte store enables (DMEM_BYTE_EN_EN builds only)
//   req_ready  request can be accepted this cycle
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load data (0 for store responses); holds outside rsp_valid
//   stall_m    freeze request for the pipeline hazard unit
//   busy_clr   post-reset clear sweep in progress
//
// state | meaning
// CLEAR | zeroing mem[clr_cnt], one word per cycle, requests refused
// IDLE  | ready, waiting for a request
// WAIT  | request latched, lat_cnt counting down to the response
// RESP  | response cycle; store commits on the closing edge, ready for next
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [BE_W-1:0]   req_be,
`endif
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              stall_m,
    output logic              busy_clr
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CLR_ONE   = ADDR_W'(1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);

    dmem_state_t       state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rdata_q;
    logic              busy_q;

    logic [BE_W-1:0]   be_in;
    logic              commit;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] rdata_d;

`ifdef DMEM_BYTE_EN_EN
    assign be_in = req_be;
`else
    assign be_in = '1;
`endif

    // A store commits on the edge that closes its RESP cycle.
    assign commit = (state_q == RESP) && we_q;

    // Write mux: clear sweep owns the port in CLEAR, store commit otherwise.
    // Reset blocks any write, so a store caught by reset is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '1;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
            end else if (commit) begin
                mem_we = 1'b1;
                mem_be = be_q;
            end
        end
    end

    // Load data is captured on the edge entering RESP. From WAIT the latched
    // address is read; with LATENCY=1 the request goes straight to RESP, so
    // the incoming address is read instead.
    assign rd_addr = (state_q == WAIT) ? addr_q : req_addr;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // A store committing on this same edge has not reached the array yet;
    // forward its bytes lane by lane.
    assign rdata_d = (commit && (rd_addr == addr_q))
                     ? merge_bytes(mem_rdata, wdata_q, be_q)
                     : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            lat_cnt_q   <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + CLR_ONE;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE, RESP: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= be_in;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= req_we ? '0 : rdata_d;
                        end else begin
                            state_q   <= WAIT;
                            lat_cnt_q <= LAT_LOAD;
                            ready_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    // Terminal count: the counter steps to zero as RESP begins.
                    lat_cnt_q <= lat_cnt_q - LAT_ONE;
                    if (lat_cnt_q == LAT_ONE) begin
                        state_q     <= RESP;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= we_q ? '0 : rdata_d;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy_clr  = busy_q;
    assign stall_m   = (req_valid && !ready_q) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=1) each run
// directed and random traffic. A word-array model computes expected data at
// acceptance time; a per-instance monitor compares responses and handshake
// signals each cycle.
module tb_dmem_responder;

    localparam int AW = 6;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int fails     = 0;

    task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (lat%0d) cyc %0d: got %h, expected %h", nm, lat, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 2 : 1;

        logic        rst;
        logic        req_valid;
        logic        req_we;
        logic [AW-1:0] req_addr;
        logic [31:0] req_wdata;
        logic [3:0]  req_be;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_rdata;
        logic        stall_m;
        logic        busy_clr;

        logic        rst_act   = 1'b1;
        logic        done      = 1'b0;
        int          clear_end = 0;
        logic [31:0] mdl [64];
        exp_t        sbq [$];

        dmem_responder #(
            .ADDR_W  (AW),
            .LATENCY (L)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
`ifdef DMEM_BYTE_EN_EN
            .req_be    (req_be),
`endif
            .req_ready (req_ready),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .stall_m   (stall_m),
            .busy_clr  (busy_clr)
        );

        always @(negedge clk) begin : mon
            bit   busy_e;
            bit   pend;
            bit   ready_e;
            exp_t e;
            if (rst_act) begin
                chk("rsp_valid_in_reset", L, 32'(rsp_valid), 32'd0);
            end else begin
                busy_e  = (cyc < clear_end);
                pend    = (sbq.size() > 0) && (cyc < sbq[0].due);
                ready_e = !busy_e && !pend;
                chk("busy_clr", L, 32'(busy_clr), 32'(busy_e));
                chk("req_ready", L, 32'(req_ready), 32'(ready_e));
                chk("stall_m", L, 32'(stall_m), 32'((req_valid && !ready_e) || pend));
                if ((sbq.size() > 0) && (sbq[0].due == cyc)) begin
                    e = sbq.pop_front();
                    chk("rsp_valid", L, 32'(rsp_valid), 32'd1);
                    if (rsp_valid) chk("rsp_rdata", L, rsp_rdata, e.data);
                end else begin
                    chk("rsp_valid_spurious", L, 32'(rsp_valid), 32'd0);
                end
            end
        end

        task automatic idle(input int n);
            req_valid = 1'b0;
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
            logic       rd;
            int         n;
            exp_t       e;
            logic [3:0] eb;
`ifdef DMEM_BYTE_EN_EN
            eb = be;
`else
            eb = 4'hF;
`endif
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = a;
            req_wdata = d;
            req_be    = be;
            n = 0;
            forever begin
                rd = req_ready;
                @(posedge clk);
                #1;
                if (rd) break;
                n++;
                if (n > 300) begin
                    $display("FAIL accept_timeout (lat%0d) cyc %0d: req_ready never rose", L, cyc);
                    $fatal(1, "bench stopped");
                end
            end
            // Accepted on the edge just taken; response lands L-1 edges later.
            e.due = cyc - 1 + L;
            if (we) begin
                mdl[a] = merge(mdl[a], d, eb);
                e.data = 32'd0;
            end else begin
                e.data = mdl[a];
            end
            sbq.push_back(e);
        endtask

        task automatic rst_seq();
            rst       = 1'b1;
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            rst_act = 1'b1;
            sbq.delete();
            for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
            @(posedge clk);
            #1;
            rst       = 1'b0;
            clear_end = cyc + 64;
            rst_act   = 1'b0;
        endtask

        initial begin
            rst       = 1'b1;
            req_valid = 1'b0;
            req_we    = 1'b0;
            req_addr  = '0;
            req_wdata = '0;
            req_be    = 4'hF;
            for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
            repeat (3) @(posedge clk);
            #1;
            rst       = 1'b0;
            clear_end = cyc + 64;
            rst_act   = 1'b0;

            issue(1'b0, 6'h3F, 32'd0, 4'hF);
            idle(3);
            issue(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
            idle(1);
            issue(1'b0, 6'd5, 32'd0, 4'hF);
            idle(3);
            issue(1'b1, 6'd9, 32'h12345678, 4'hF);
            issue(1'b0, 6'd9, 32'd0, 4'hF);
            idle(3);
            for (int a = 1; a <= 4; a++) issue(1'b0, AW'(a), 32'd0, 4'hF);
            idle(3);
`ifdef DMEM_BYTE_EN_EN
            issue(1'b1, 6'd12, 32'hAABBCCDD, 4'hF);
            issue(1'b1, 6'd12, 32'h11223344, 4'b0101);
            issue(1'b0, 6'd12, 32'd0, 4'hF);
            idle(3);
`endif
            repeat (120) begin
                issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
                idle($urandom_range(0, 2));
            end
            idle(3);

            issue(1'b1, 6'd7, 32'hCAFEF00D, 4'hF);
            rst_seq();
            issue(1'b0, 6'd7, 32'd0, 4'hF);
            idle(L + 3);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            if (u[0].done && u[1].done) break;
            @(posedge clk);
        end
        if (!(u[0].done && u[1].done)) begin
            $display("FAIL sim_timeout: stimulus did not complete, done=%b%b", u[0].done, u[1].done);
            $fatal(1, "bench stopped");
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
